ccip_c0_req_arbiter: RTL

Shares the single CCI-P C0 TX (memory read request) channel between NUM_REQ AFU-side requesters using round-robin arbitration, honouring c0TxAlmFull and a global outstanding-read limit. It tags each issued request's mdata with the requester index and steers C0 RX read responses back to the originating requester. It sits between AFU request engines and the CCI-P port, upstream of the protocol checker.

---
 rtl/ccip_c0_arb_pkg.sv | 38 +++
 rtl/ccip_rr_arbiter.sv | 42 ++++
 rtl/ccip_c0_req_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/ccip_c0_arb_pkg.sv
// ----------------------------------------------------------------------------
// ccip_c0_arb_pkg
// Shared definitions for the CCI-P C0 read-request arbiter:
//   - default header / response data widths
//   - mdata field offsets inside the C0 TX request header
//   - t_c0_req_hdr view of a default-width request header
//   - tag_insert / tag_strip helpers that place or remove the requester
//     index in the top ID_W bits of mdata
// ----------------------------------------------------------------------------
package ccip_c0_arb_pkg;

  localparam int HDR_W_DEF  = 74;
  localparam int DATA_W_DEF = 512;
  localparam int MDATA_LO   = 0;
  localparam int MDATA_HI   = 15;
  localparam int MDATA_W    = MDATA_HI - MDATA_LO + 1;

  typedef struct packed {
    logic [HDR_W_DEF-MDATA_W-1:0] rsvd;
    logic [MDATA_W-1:0]           mdata;
  } t_c0_req_hdr;

  // Overwrite the top id_w bits of mdata with the requester index.
  function automatic logic [15:0] tag_insert(input logic [15:0] mdata,
                                             input logic [7:0]  id,
                                             input int          id_w);
    logic [15:0] tag_mask;
    tag_mask = ~(16'hFFFF >> id_w);
    return (mdata & ~tag_mask) | ((16'(id) << (16 - id_w)) & tag_mask);
  endfunction

  // Clear the tag bits so the requester sees only the mdata it owns.
  function automatic logic [15:0] tag_strip(input logic [15:0] mdata,
                                            input int          id_w);
    return mdata & (16'hFFFF >> id_w);
  endfunction

endpackage

// File: rtl/ccip_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ccip_rr_arbiter
// Combinational round-robin grant. Searches req starting at the index after
// last and wrapping modulo N; the first asserted request wins.
//   req      in  N   request vector
//   en       in  1   grant enable (no grant when low)
//   last     in  IW  index of the previous winner
//   gnt      out N   one-hot grant (zero when disabled or idle)
//   gnt_idx  out IW  index of the winning request
//   gnt_any  out 1   a grant is issued this cycle
// ----------------------------------------------------------------------------
module ccip_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx     = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    gnt_any = en && found;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/ccip_c0_req_arbiter.sv
// ----------------------------------------------------------------------------
// ccip_c0_req_arbiter
// Shares the CCI-P C0 TX read-request channel between NUM_REQ requesters
// with round-robin arbitration, gated by c0TxAlmFull and an outstanding-read
// limit. Issued requests carry the requester index in mdata[15:16-ID_W];
// C0 RX responses are steered back by that tag with the tag bits cleared.
//   clk, SoftReset            clock, synchronous active-high reset
//   req_valid/req_hdr/req_ready  per-requester request handshake
//   c0tx_valid/c0tx_hdr       registered request to CCI-P
//   c0TxAlmFull               CCI-P back-pressure
//   c0rx_rspValid/mdata/data  read response from CCI-P
//   rsp_valid/mdata/data      one-hot steered response to requesters
//   outstanding               reads in flight
//   err_underflow             sticky: response seen with nothing in flight
// ----------------------------------------------------------------------------
module ccip_c0_req_arbiter
  import ccip_c0_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int HDR_W           = HDR_W_DEF,
  parameter  int DATA_W          = DATA_W_DEF,
  parameter  int MAX_OUTSTANDING = 64,
  localparam int ID_W            = $clog2(NUM_REQ),
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            SoftReset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][HDR_W-1:0]   req_hdr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            c0tx_valid,
  output logic [HDR_W-1:0]                c0tx_hdr,
  input  logic                            c0TxAlmFull,
  input  logic                            c0rx_rspValid,
  input  logic [15:0]                     c0rx_mdata,
  input  logic [DATA_W-1:0]               c0rx_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [15:0]                     rsp_mdata,
  output logic [DATA_W-1:0]               rsp_data,
  output logic [OUT_W-1:0]                outstanding,
  output logic                            err_underflow
);

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  gnt_idx_p0;
  logic             xfer_p0;
  logic             can_issue;
  logic [HDR_W-1:0] hdr_tagged_p0;
  logic [ID_W-1:0]  rsp_id_p0;

  assign can_issue = !c0TxAlmFull && (outstanding < OUT_W'(MAX_OUTSTANDING));

  ccip_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req     (req_valid),
    .en      (can_issue),
    .last    (last_grant),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx_p0),
    .gnt_any (xfer_p0)
  );

  always_comb begin
    hdr_tagged_p0 = req_hdr[gnt_idx_p0];
    hdr_tagged_p0[MDATA_HI:MDATA_LO] =
      tag_insert(req_hdr[gnt_idx_p0][MDATA_HI:MDATA_LO], 8'(gnt_idx_p0), ID_W);
  end

  assign rsp_id_p0 = c0rx_mdata[15 -: ID_W];

  // Stage p0 -> p1: request/response registers and in-flight accounting
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      last_grant    <= ID_W'(NUM_REQ - 1);
      c0tx_valid    <= 1'b0;
      c0tx_hdr      <= '0;
      rsp_valid     <= '0;
      rsp_mdata     <= '0;
      rsp_data      <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      c0tx_valid <= xfer_p0;
      if (xfer_p0) begin
        last_grant <= gnt_idx_p0;
        c0tx_hdr   <= hdr_tagged_p0;
      end

      rsp_valid <= '0;
      if (c0rx_rspValid) begin
        if (int'(rsp_id_p0) < NUM_REQ) rsp_valid[rsp_id_p0] <= 1'b1;
        rsp_mdata <= tag_strip(c0rx_mdata, ID_W);
        rsp_data  <= c0rx_data;
      end

      // Simultaneous issue and response cancel; a response with nothing in
      // flight cannot have come from us, so flag it and keep the count at 0.
      unique case ({xfer_p0, c0rx_rspValid})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) err_underflow <= 1'b1;
          else                   outstanding   <= outstanding - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
